// File: rtl/ha_acc_pkg.sv
// Shared types and constants for the half-adder array row accumulator.
// Rows are weighted by 4^i and summed serially into a saturating product.
package ha_acc_pkg;

    localparam int NUM_ROWS = 4;
    localparam int T_W      = 9;
    localparam int B_W      = 7;
    localparam int P_W      = 16;
    localparam int ACC_W    = P_W + 1;
    localparam int ROW_W    = 10;
    localparam int CNT_W    = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    typedef struct packed {
        logic [T_W-1:0] t;
        logic [B_W-1:0] b;
    } row_t;

    // Row i sits at bit position 2*i of the product.
    function automatic logic [ACC_W-1:0] weigh_row(
        input logic [ROW_W-1:0] rowval,
        input logic [CNT_W-1:0] idx
    );
        return {{(ACC_W-ROW_W){1'b0}}, rowval} << {idx, 1'b0};
    endfunction

endpackage

// File: rtl/ha_row_weigh.sv
// Combines one half-adder row into its 10-bit value: the carry vector
// sits two bit positions above the top vector.
module ha_row_weigh
    import ha_acc_pkg::*;
(
    input  logic [T_W-1:0]   t,
    input  logic [B_W-1:0]   b,
    output logic [ROW_W-1:0] rowval
);

    assign rowval = {1'b0, t} + {1'b0, b, 2'b00};

endmodule

// File: rtl/ha_array_accumulator.sv
// Captures the four half-adder rows, accumulates them one per cycle into a
// 17-bit sum and presents a saturated 16-bit product with valid/ready.
module ha_array_accumulator
    import ha_acc_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [T_W-1:0] ha_array_0_t,
    input  logic [B_W-1:0] ha_array_0_b,
    input  logic [T_W-1:0] ha_array_1_t,
    input  logic [B_W-1:0] ha_array_1_b,
    input  logic [T_W-1:0] ha_array_2_t,
    input  logic [B_W-1:0] ha_array_2_b,
    input  logic [T_W-1:0] ha_array_3_t,
    input  logic [B_W-1:0] ha_array_3_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] product,
    output logic           ovf
);

    state_t           state;
    row_t             rows [NUM_ROWS];
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;

    row_t             sel_row;
    logic [ROW_W-1:0] rowval;
    logic [ACC_W-1:0] acc_next;

    // A single weigher is time-shared across the rows through the cnt mux.
    assign sel_row  = rows[cnt];
    assign acc_next = acc + weigh_row(rowval, cnt);

    ha_row_weigh u_row_weigh (
        .t      (sel_row.t),
        .b      (sel_row.b),
        .rowval (rowval)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                rows[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rows[0]  <= {ha_array_0_t, ha_array_0_b};
                        rows[1]  <= {ha_array_1_t, ha_array_1_b};
                        rows[2]  <= {ha_array_2_t, ha_array_2_b};
                        rows[3]  <= {ha_array_3_t, ha_array_3_b};
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ACC;
                    end
                end

                // The last row's sum is taken straight from acc_next so the
                // product is registered on the same edge that enters DONE.
                ACC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NUM_ROWS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        product   <= acc_next[P_W] ? {P_W{1'b1}} : acc_next[P_W-1:0];
                        ovf       <= acc_next[P_W];
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Scoreboard bench for ha_array_accumulator: directed corner cases followed
// by randomized rows with random backpressure, checked against an arithmetic model.
module tb_ha_array_accumulator;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0][8:0] t_drv;
    logic [3:0][6:0] b_drv;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     product;
    logic            ovf;

    logic            ready_manual;
    logic            bp_rand;
    bit              random_bp;

    logic [16:0]     exp_q[$];
    int              checks = 0;
    int              errors = 0;

    assign out_ready = random_bp ? bp_rand : ready_manual;

    always #5 clk = ~clk;

    ha_array_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_t (t_drv[0]),
        .ha_array_0_b (b_drv[0]),
        .ha_array_1_t (t_drv[1]),
        .ha_array_1_b (b_drv[1]),
        .ha_array_2_t (t_drv[2]),
        .ha_array_2_b (b_drv[2]),
        .ha_array_3_t (t_drv[3]),
        .ha_array_3_b (b_drv[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .ovf          (ovf)
    );

    // Reference: each row is worth (t + 4*b) * 4^i; the total saturates at 16 bits.
    function automatic logic [16:0] model(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
        int unsigned sum = 0;
        for (int i = 0; i < 4; i++) begin
            sum += (int'(t[i]) + 4 * int'(b[i])) * (1 << (2 * i));
        end
        if (sum > 65535) return {1'b1, 16'hFFFF};
        return {1'b0, sum[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endtask

    // Presents one row set, waits for the accept edge, then drives junk for a
    // cycle to show that post-handshake input changes are ignored.
    task automatic applyStimulus(input logic [3:0][8:0] t, input logic [3:0][6:0] b, input bit expect_out);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            reportTimeout("accept_wait");
            return;
        end
        t_drv    = t;
        b_drv    = b;
        in_valid = 1'b1;
        if (expect_out) exp_q.push_back(model(t, b));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            t_drv[i] = 9'($urandom);
            b_drv[i] = 7'($urandom);
        end
        in_valid = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || !in_ready) && n < 60);
        if (exp_q.size() != 0 || !in_ready) reportTimeout("wait_idle");
    endtask

    // Monitor: every completed output handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: product 0x%0h with empty scoreboard at %0t", product, $time);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                checkOutput("product", 32'(product), 32'(e[15:0]));
                checkOutput("ovf", 32'(ovf), 32'(e[16]));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bp_rand = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        logic [16:0]     e;
        int              n;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        t_drv        = '0;
        b_drv        = '0;
        ready_manual = 1'b1;
        bp_rand      = 1'b1;
        random_bp    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_product", 32'(product), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);

        // All-zero rows: out_valid must appear exactly five cycles after the accept.
        t = '0;
        b = '0;
        applyStimulus(t, b, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("latency_in_ready_c%0d", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("latency_out_valid_c%0d", k), 32'(out_valid), 32'(k == 5));
        end
        waitIdle();

        t = '0; b = '0; t[0] = 9'h001;
        applyStimulus(t, b, 1'b1);
        waitIdle();
        t = '0; b = '0; b[3] = 7'h40;
        applyStimulus(t, b, 1'b1);
        waitIdle();
        t = '0; b = '0; t[2] = 9'h100;
        applyStimulus(t, b, 1'b1);
        waitIdle();
        for (int i = 0; i < 4; i++) begin
            t[i] = 9'h1FF;
            b[i] = 7'h7F;
        end
        applyStimulus(t, b, 1'b1);
        waitIdle();

        // Backpressure: the result must stay put while the consumer stalls.
        ready_manual = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t[i] = 9'($urandom);
            b[i] = 7'($urandom);
        end
        e = model(t, b);
        applyStimulus(t, b, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) reportTimeout("bp_out_valid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_product", 32'(product), 32'(e[15:0]));
        end
        @(posedge clk);
        #1;
        ready_manual = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        t = '0; b = '0; t[1] = 9'h005; b[0] = 7'h01;
        applyStimulus(t, b, 1'b1);
        waitIdle();

        // Reset in the second ACC cycle discards the transaction silently.
        for (int i = 0; i < 4; i++) begin
            t[i] = 9'($urandom);
            b[i] = 7'($urandom);
        end
        applyStimulus(t, b, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_product", 32'(product), 32'd0);
        checkOutput("midreset_ovf", 32'(ovf), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("midreset_no_output", 32'(out_valid), 32'd0);
        end
        t = '0; b = '0; t[1] = 9'h003;
        applyStimulus(t, b, 1'b1);
        waitIdle();

        // Randomized traffic with random idle gaps and random backpressure.
        random_bp = 1'b1;
        for (int n_tx = 0; n_tx < 40; n_tx++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: begin t[i] = '0;     b[i] = '0;    end
                    1: begin t[i] = 9'h1FF; b[i] = 7'h7F; end
                    default: begin
                        t[i] = 9'($urandom);
                        b[i] = 7'($urandom);
                    end
                endcase
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(t, b, 1'b1);
        end
        random_bp = 1'b0;
        waitIdle();
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
